esteira_ctrl_n: RTL
===================

Name: esteira_ctrl_n

Overview:
Multi-channel conveyor belt controller. Each of N_BELTS belts has its own run FSM driving its motor enable.
- Guard sensor debouncing, restart delay before motor start, jam detection with latched fault, global emergency stop.
- Sits between the operator/PLC input layer and the motor driver outputs.
- Replaces the single-belt two-state controller.

Parameters:
N_BELTS, 4, number of independent belt channels (>=1)
DEB_CYCLES, 4, consecutive stable cycles before the debounced guard changes (>=1)
RESTART_DLY, 16, cycles spent in ARMING before the motor starts (>=1)
JAM_CYCLES, 200, cycles of start-request-while-guarded before a jam fault (>=2)
CNT_W, 8, width of the per-channel delay/jam counters; must hold max(DEB_CYCLES, RESTART_DLY, JAM_CYCLES)

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high
st  input  N_BELTS  per-belt start request, level (1 = run wanted)
pg  input  N_BELTS  per-belt guard/obstruction sensor, raw (1 = blocked)
estop  input  1  global emergency stop, level
clr_fault  input  N_BELTS  per-belt fault clear, level
m  output  N_BELTS  motor enable, registered
fault  output  N_BELTS  jam fault latched, registered
n_moving  output  $clog2(N_BELTS+1)  count of belts in MOVING, registered

Behaviour:
Reset (async): all FSMs STOPPED, counters 0, pg_db = all 1s (blocked), m=0, fault=0, n_moving=0.

Debounce (per belt):
- pg_db[i] takes the value of pg[i] only after pg[i] differs from pg_db[i] for DEB_CYCLES consecutive cycles.
- Any cycle where pg[i] equals pg_db[i] clears the debounce counter.
- Once reset is released, a belt with pg=0 cannot start for at least DEB_CYCLES cycles.

Per-belt FSM: STOPPED, ARMING, MOVING, FAULT. Evaluated on each clk edge. Priority order per cycle: FAULT hold > estop > jam > normal transitions.
- STOPPED: st & ~pg_db & ~estop -> ARMING, delay counter cleared.
- ARMING: delay counter increments each cycle.
  - ~st or pg_db or estop -> STOPPED.
  - Counter == RESTART_DLY-1 -> MOVING.
  - ARMING therefore lasts exactly RESTART_DLY cycles.
- MOVING: ~st or pg_db or estop -> STOPPED.
- FAULT: stays in FAULT regardless of estop and st. Exits to STOPPED when clr_fault & ~pg_db.
- Jam detection:
  - The jam counter increments in any non-FAULT state while st & pg_db, saturating at JAM_CYCLES.
  - It clears whenever ~(st & pg_db).
  - Reaching JAM_CYCLES -> FAULT next cycle, counter cleared.

Outputs:
- m[i] = 1 exactly when belt i's registered state is MOVING.
- fault[i] = 1 exactly when the state is FAULT.
- n_moving = popcount of MOVING states, registered in the same cycle as m.
- Latency: st asserted (with pg_db=0 already settled) at edge t gives m high at edge t+1+RESTART_DLY.
- Any stop condition sampled at edge t gives m low after edge t+1.

Boundary conditions:
- Channels are fully independent, except for the shared estop and the optional interlock.
- estop held: no belt leaves STOPPED. FAULT belts remain faulted. Releasing estop does not auto-restart a belt that was moving; it re-enters ARMING only via the normal STOPPED path, and only if st is still high.
- Reset mid-ARMING or mid-MOVING: immediate STOPPED, m=0 asynchronously at the register output.
- clr_fault asserted while pg_db=1: ignored; fault stays latched.

Optional Feature:
Macro ESTEIRA_CASCADE_INTERLOCK_EN.
- Defined: belt N_BELTS-1 is the discharge (most downstream) belt.
  - Belt i < N_BELTS-1 may leave ARMING for MOVING only if belt i+1 is MOVING; otherwise it holds in ARMING with the counter held at RESTART_DLY-1.
  - A MOVING belt i goes to STOPPED the cycle after belt i+1 leaves MOVING.
  - This guarantees no belt feeds a stopped downstream belt.
- Undefined: no inter-channel dependency; interlock logic is absent.

Test Plan:
- Reset release with pg=0, st[0]=1 held (DEB=4, DLY=16) -> m[0] rises exactly 4+1+16 cycles after reset release; n_moving=1.
- pg[1] glitch high for 3 cycles while belt 1 MOVING -> m[1] stays 1. A 4-cycle pulse -> m[1] drops 1 cycle after debounce switches, and belt 1 re-arms for 16 cycles once the guard clears.
- st[2]=1 with pg[2]=1 held 200 cycles -> fault[2]=1, m[2]=0. clr_fault[2] while pg_db=1 -> still faulted. After pg clears and debounces, clr_fault[2] -> STOPPED, then ARMING if st high.
- estop pulse while belts 0,1,3 MOVING and belt 2 FAULT -> m=0000 next cycle, fault[2] stays 1. After estop drops, belts 0,1,3 reach MOVING 17 cycles later.
- With ESTEIRA_CASCADE_INTERLOCK_EN, st=1111, pg=0 -> belt 3 moves first; belts 2, 1, 0 each follow 1 cycle after their downstream belt. Dropping st[3] -> belts 2, 1, 0 stop in successive cycles.

Source files
------------

// File: rtl/esteira_ctrl_n.sv
// esteira_ctrl_n -- multi-channel conveyor belt controller.
//
// Each belt channel debounces its raw guard sensor and runs its own
// STOPPED / ARMING / MOVING / FAULT state machine. A belt starts only after
// a fixed restart delay. A start request held while the guard is blocked
// for too long latches a jam fault. A global emergency stop halts every belt
// that is not faulted.
//
// Optional build macro: ESTEIRA_CASCADE_INTERLOCK_EN
//   When defined, belt N_BELTS-1 is the discharge belt. A belt may only
//   start moving while its downstream neighbour is moving, and it stops one
//   cycle after that neighbour stops.
//
// Ports:
//   clk          system clock, rising edge
//   reset        asynchronous, active-high reset
//   st_i         per-belt start request (level, 1 = run wanted)
//   pg_i         per-belt raw guard sensor (1 = blocked)
//   estop_i      global emergency stop (level)
//   clr_fault_i  per-belt fault clear (level)
//   m_o          per-belt motor enable (registered)
//   fault_o      per-belt latched jam fault (registered)
//   n_moving_o   number of belts currently MOVING (registered)
module esteira_ctrl_n #(
  parameter int N_BELTS     = 4,
  parameter int DEB_CYCLES  = 4,
  parameter int RESTART_DLY = 16,
  parameter int JAM_CYCLES  = 200,
  parameter int CNT_W       = 8,
  localparam int NM_W       = $clog2(N_BELTS + 1)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [N_BELTS-1:0] st_i,
  input  logic [N_BELTS-1:0] pg_i,
  input  logic               estop_i,
  input  logic [N_BELTS-1:0] clr_fault_i,
  output logic [N_BELTS-1:0] m_o,
  output logic [N_BELTS-1:0] fault_o,
  output logic [NM_W-1:0]    n_moving_o
);

  typedef enum logic [1:0] {
    ST_STOPPED = 2'd0,
    ST_ARMING  = 2'd1,
    ST_MOVING  = 2'd2,
    ST_FAULT   = 2'd3
  } state_e;

  localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEB_CYCLES - 1);
  localparam logic [CNT_W-1:0] DLY_LAST = CNT_W'(RESTART_DLY - 1);
  localparam logic [CNT_W-1:0] JAM_MAX  = CNT_W'(JAM_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  state_e             state_q   [N_BELTS];
  state_e             state_d   [N_BELTS];
  logic [CNT_W-1:0]   deb_cnt_q [N_BELTS];
  logic [CNT_W-1:0]   deb_cnt_d [N_BELTS];
  logic [CNT_W-1:0]   dly_cnt_q [N_BELTS];
  logic [CNT_W-1:0]   dly_cnt_d [N_BELTS];
  logic [CNT_W-1:0]   jam_cnt_q [N_BELTS];
  logic [CNT_W-1:0]   jam_cnt_d [N_BELTS];
  logic [N_BELTS-1:0] pg_db_q, pg_db_d;
  logic [N_BELTS-1:0] m_q, m_d;
  logic [N_BELTS-1:0] fault_q, fault_d;
  logic [NM_W-1:0]    n_moving_q, n_moving_d;
  logic [N_BELTS-1:0] dn_ok_s;

  // Downstream permission: a belt may move only while its downstream belt moves.
  always_comb begin
    dn_ok_s = '1;
`ifdef ESTEIRA_CASCADE_INTERLOCK_EN
    for (int i = 0; i < N_BELTS - 1; i++) begin
      dn_ok_s[i] = (state_q[i+1] == ST_MOVING);
    end
`endif
  end

  // Guard debounce: adopt the raw value after DEB_CYCLES consecutive disagreements.
  always_comb begin
    pg_db_d = pg_db_q;
    for (int i = 0; i < N_BELTS; i++) begin
      deb_cnt_d[i] = deb_cnt_q[i];
      if (pg_i[i] != pg_db_q[i]) begin
        if (deb_cnt_q[i] == DEB_LAST) begin
          pg_db_d[i]   = pg_i[i];
          deb_cnt_d[i] = '0;
        end else begin
          deb_cnt_d[i] = deb_cnt_q[i] + CNT_ONE;
        end
      end else begin
        deb_cnt_d[i] = '0;
      end
    end
  end

  // Per-belt run FSM, jam counter and next-state outputs.
  always_comb begin
    m_d        = '0;
    fault_d    = '0;
    n_moving_d = '0;
    for (int i = 0; i < N_BELTS; i++) begin
      state_d[i]   = state_q[i];
      dly_cnt_d[i] = dly_cnt_q[i];
      jam_cnt_d[i] = jam_cnt_q[i];
      if (state_q[i] == ST_FAULT) begin
        // Fault is sticky; only an explicit clear with a clear guard releases it.
        jam_cnt_d[i] = '0;
        if (clr_fault_i[i] && !pg_db_q[i]) begin
          state_d[i] = ST_STOPPED;
        end else begin
          state_d[i] = ST_FAULT;
        end
      end else begin
        // Jam counter saturates so a jam seen during estop faults once estop drops.
        if (st_i[i] && pg_db_q[i]) begin
          if (jam_cnt_q[i] != JAM_MAX) begin
            jam_cnt_d[i] = jam_cnt_q[i] + CNT_ONE;
          end else begin
            jam_cnt_d[i] = jam_cnt_q[i];
          end
        end else begin
          jam_cnt_d[i] = '0;
        end

        if (estop_i) begin
          state_d[i] = ST_STOPPED;
        end else if (st_i[i] && pg_db_q[i] && (jam_cnt_q[i] == JAM_MAX)) begin
          state_d[i]   = ST_FAULT;
          jam_cnt_d[i] = '0;
        end else begin
          case (state_q[i])
            ST_STOPPED: begin
              if (st_i[i] && !pg_db_q[i]) begin
                state_d[i]   = ST_ARMING;
                dly_cnt_d[i] = '0;
              end else begin
                state_d[i] = ST_STOPPED;
              end
            end
            ST_ARMING: begin
              if (!st_i[i] || pg_db_q[i]) begin
                state_d[i] = ST_STOPPED;
              end else if (dly_cnt_q[i] == DLY_LAST) begin
                // Counter holds at its last value while waiting for downstream.
                if (dn_ok_s[i]) begin
                  state_d[i] = ST_MOVING;
                end else begin
                  state_d[i] = ST_ARMING;
                end
              end else begin
                dly_cnt_d[i] = dly_cnt_q[i] + CNT_ONE;
              end
            end
            ST_MOVING: begin
              if (!st_i[i] || pg_db_q[i] || !dn_ok_s[i]) begin
                state_d[i] = ST_STOPPED;
              end else begin
                state_d[i] = ST_MOVING;
              end
            end
            default: begin
              state_d[i] = ST_STOPPED;
            end
          endcase
        end
      end
      m_d[i]     = (state_d[i] == ST_MOVING);
      fault_d[i] = (state_d[i] == ST_FAULT);
      if (state_d[i] == ST_MOVING) begin
        n_moving_d = n_moving_d + NM_W'(1);
      end else begin
        n_moving_d = n_moving_d;
      end
    end
  end

  // State, counters and registered outputs; guard starts out as blocked.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < N_BELTS; i++) begin
        state_q[i]   <= ST_STOPPED;
        deb_cnt_q[i] <= '0;
        dly_cnt_q[i] <= '0;
        jam_cnt_q[i] <= '0;
      end
      pg_db_q    <= '1;
      m_q        <= '0;
      fault_q    <= '0;
      n_moving_q <= '0;
    end else begin
      for (int i = 0; i < N_BELTS; i++) begin
        state_q[i]   <= state_d[i];
        deb_cnt_q[i] <= deb_cnt_d[i];
        dly_cnt_q[i] <= dly_cnt_d[i];
        jam_cnt_q[i] <= jam_cnt_d[i];
      end
      pg_db_q    <= pg_db_d;
      m_q        <= m_d;
      fault_q    <= fault_d;
      n_moving_q <= n_moving_d;
    end
  end

  assign m_o        = m_q;
  assign fault_o    = fault_q;
  assign n_moving_o = n_moving_q;

endmodule
